// File: rtl/l1_cache_if.sv
// CPU-side word port and memory-side line port of the L1 cache.
// master = requester/memory side, slave = cache.
interface l1_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache: 16-bit words, 128-bit lines.
// Optional hit/miss counters are built when L1_CACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | serve hits combinationally, launch a miss
// WRITEBACK | evicting dirty victim line to pmem
// ALLOCATE  | filling requested line from pmem
module l1_cache #(
    parameter int SET_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    l1_cache_if.slave   bus
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int TAG_W = 12 - SET_BITS;
    localparam int LINES = 1 << SET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                state;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [127:0]          data_q [LINES];

    logic [TAG_W-1:0]      req_tag;
    logic [SET_BITS-1:0]   req_idx;
    logic                  pmem_read_q;
    logic                  pmem_write_q;
    logic [15:0]           pmem_address_q;

    logic [TAG_W-1:0]      addr_tag;
    logic [SET_BITS-1:0]   addr_idx;
    logic [2:0]            word_sel;
    logic                  req;
    logic                  hit;
    logic [127:0]          line_merged;
    logic                  unused_addr_lsb;

    assign addr_tag        = bus.mem_address[15:4+SET_BITS];
    assign addr_idx        = bus.mem_address[3+SET_BITS:4];
    assign word_sel        = bus.mem_address[3:1];
    assign unused_addr_lsb = bus.mem_address[0];
    assign req             = bus.mem_read | bus.mem_write;
    assign hit             = (state == IDLE) && req && valid_q[addr_idx]
                             && (tag_q[addr_idx] == addr_tag);

    assign bus.mem_resp     = hit;
    assign bus.mem_rdata    = hit ? data_q[addr_idx][{word_sel, 4'b0000} +: 16] : 16'h0000;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = data_q[req_idx];

    always_comb begin
        line_merged = data_q[addr_idx];
        if (bus.mem_byte_enable[0]) line_merged[{word_sel, 4'b0000} +: 8] = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) line_merged[{word_sel, 4'b1000} +: 8] = bus.mem_wdata[15:8];
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (hit && bus.mem_write) begin
            data_q[addr_idx] <= line_merged;
        end else if (state == ALLOCATE && bus.pmem_resp) begin
            data_q[req_idx] <= bus.pmem_rdata;
            tag_q[req_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            valid_q        <= '0;
            dirty_q        <= '0;
            req_tag        <= '0;
            req_idx        <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && bus.mem_write) begin
                        dirty_q[addr_idx] <= 1'b1;
                    end else if (req && !hit) begin
                        req_tag <= addr_tag;
                        req_idx <= addr_idx;
                        if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                            state          <= WRITEBACK;
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_q[addr_idx], addr_idx, 4'b0000};
                        end else begin
                            state          <= ALLOCATE;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {addr_tag, addr_idx, 4'b0000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state          <= ALLOCATE;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {req_tag, req_idx, 4'b0000};
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        state            <= IDLE;
                        pmem_read_q      <= 1'b0;
                        pmem_address_q   <= 16'h0000;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L1_CACHE_STATS_EN
    // The completion cycle of a miss is not a hit; just_filled masks it.
    logic just_filled;

    always_ff @(posedge clk) begin
        if (reset) begin
            just_filled <= 1'b0;
            hit_count   <= 16'h0000;
            miss_count  <= 16'h0000;
        end else begin
            just_filled <= (state == ALLOCATE) && bus.pmem_resp;
            if (hit && !just_filled && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'h0001;
            if (state == IDLE && req && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'h0001;
        end
    end
`endif
endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios then random traffic,
// checked against a line-level memory model and a per-set residency model.
module tb_l1_cache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_cache_if bus ();

`ifdef L1_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    l1_cache dut (.clk(clk), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
    l1_cache dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    int vectors = 0;
    int fails   = 0;

    // pmem backing store and architectural (latest-written) view, per line.
    logic [127:0] pmem_mem [logic [11:0]];
    logic [127:0] arch_mem [logic [11:0]];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [8:0]   m_tag   [8];
    int           exp_hit  = 0;
    int           exp_miss = 0;

    int           lat = 3;
    int           n_rd = 0;
    int           n_wr = 0;
    logic [15:0]  fill_addr;
    logic [15:0]  wb_addr;
    logic [127:0] wb_data;
    logic [15:0]  last_rdata;

    function automatic logic [127:0] line_init(input logic [11:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = {la, 4'(k)} ^ 16'h5A5A;
        return l;
    endfunction

    function automatic logic [127:0] pmem_get(input logic [11:0] la);
        if (pmem_mem.exists(la)) return pmem_mem[la];
        return line_init(la);
    endfunction

    function automatic logic [127:0] arch_get(input logic [11:0] la);
        if (arch_mem.exists(la)) return arch_mem[la];
        return pmem_get(la);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pmem responder: pmem_resp after lat cycles of a held request.
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
                if (cnt == lat) begin
                    cnt = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        pmem_mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
                        wb_addr = bus.pmem_address;
                        wb_data = bus.pmem_wdata;
                        n_wr++;
                    end else begin
                        bus.pmem_rdata = pmem_get(bus.pmem_address[15:4]);
                        fill_addr = bus.pmem_address;
                        n_rd++;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            assert (!(bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1)) else begin
                fails++;
                $error("FAIL pmem_rw_exclusive: observed both high expected one");
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        arch_mem.delete();
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [1:0] be,
                          input logic [15:0] wdata);
        logic [11:0]  la, old_la;
        logic [2:0]   idx, w;
        logic [8:0]   tg;
        logic [127:0] line;
        bit           hit, dev;
        int           rd0, wr0, cyc, exp_lat;
        la  = addr[15:4];
        idx = addr[6:4];
        tg  = addr[15:7];
        w   = addr[3:1];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        dev = !hit && m_valid[idx] && m_dirty[idx];
        old_la  = {m_tag[idx], idx};
        exp_lat = hit ? 0 : (dev ? 2*lat + 3 : lat + 2);
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk); #1;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wdata;
        cyc = 0;
        while (cyc <= 40) begin
            @(negedge clk);
            if (bus.mem_resp === 1'b1) break;
            cyc++;
        end
        check("resp_latency", 128'(cyc), 128'(exp_lat));
        line = arch_get(la);
        last_rdata = bus.mem_rdata;
        if (!wr) check("rdata", bus.mem_rdata, line[int'(w)*16 +: 16]);
        check("pmem_read_count", 128'(n_rd - rd0), hit ? 128'd0 : 128'd1);
        check("pmem_write_count", 128'(n_wr - wr0), dev ? 128'd1 : 128'd0);
        if (!hit) check("fill_addr", fill_addr, {la, 4'b0000});
        if (dev) begin
            check("wb_addr", wb_addr, {old_la, 4'b0000});
            check("wb_data", wb_data, arch_get(old_la));
        end
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (hit) exp_hit++;
        else     exp_miss++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (!hit) m_dirty[idx] = 1'b0;
        if (wr) begin
            if (be[0]) line[int'(w)*16 +: 8]     = wdata[7:0];
            if (be[1]) line[int'(w)*16 + 8 +: 8] = wdata[15:8];
            arch_mem[la] = line;
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] tmp;
        logic [8:0]   tags [4];
        reset               = 1'b1;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_address     = 16'h0000;
        bus.mem_wdata       = 16'h0000;
        tmp = line_init(12'h001);
        tmp[31:16] = 16'hBEEF;
        pmem_mem[12'h001] = tmp;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", bus.mem_resp, 1'b0);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_pmem_address", bus.pmem_address, 16'h0000);
        check("rst_mem_rdata", bus.mem_rdata, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;

        // Cold read, then partial write, then read back.
        lat = 3;
        do_req(1'b0, 16'h0012, 2'b00, 16'h0000);
        check("cold_rdata_beef", last_rdata, 16'hBEEF);
        do_req(1'b1, 16'h0012, 2'b01, 16'h1234);
        do_req(1'b0, 16'h0012, 2'b00, 16'h0000);
        check("merge_rdata_be34", last_rdata, 16'hBE34);

        // Dirty conflict eviction, then the clean victim evicts silently.
        do_req(1'b0, 16'h0092, 2'b00, 16'h0000);
        check("wb_word1_be34", wb_data[31:16], 16'hBE34);
        do_req(1'b0, 16'h0012, 2'b00, 16'h0000);

        // Last index, last word.
        do_req(1'b0, 16'h0FFE, 2'b00, 16'h0000);
        do_req(1'b1, 16'h0FFE, 2'b11, 16'hC0DE);
        do_req(1'b0, 16'h0FFE, 2'b00, 16'h0000);
        check("word7_rdata", last_rdata, 16'hC0DE);
        do_req(1'b0, 16'h0F8E, 2'b00, 16'h0000);

        // Reset while ALLOCATE is outstanding.
        lat = 4;
        @(posedge clk); #1;
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0234;
        begin
            int n;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                if (bus.pmem_read === 1'b1) break;
                n++;
            end
            check("abort_pmem_read_seen", bus.pmem_read, 1'b1);
        end
        @(posedge clk); #1;
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_pmem_read_low", bus.pmem_read, 1'b0);
        check("abort_pmem_address", bus.pmem_address, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();

        // miss, hit, hit, miss (dirty victim).
        do_req(1'b0, 16'h0234, 2'b00, 16'h0000);
        do_req(1'b0, 16'h0234, 2'b00, 16'h0000);
        do_req(1'b1, 16'h0236, 2'b10, 16'h77AA);
        do_req(1'b0, 16'h0A34, 2'b00, 16'h0000);
`ifdef L1_CACHE_STATS_EN
        @(negedge clk);
        check("stats_miss_count", miss_count, 16'd2);
        check("stats_hit_count", hit_count, 16'd2);
`endif

        tags[0] = 9'h000;
        tags[1] = 9'h001;
        tags[2] = 9'h1FF;
        tags[3] = 9'h0A5;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            a   = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            lat = $urandom_range(1, 4);
            do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                   16'($urandom));
        end

`ifdef L1_CACHE_STATS_EN
        @(negedge clk);
        check("stats_total_miss", miss_count, 16'(exp_miss));
        check("stats_total_hit", hit_count, 16'(exp_hit));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
